// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential RV32M divide unit.
package alu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DIV_ITER = 32;
   localparam int unsigned CNT_W    = $clog2(DIV_ITER);

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } div_state_e;

   // Two's complement negation; |0x80000000| stays 0x80000000 read as unsigned.
   function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
      return XLEN'(~x + XLEN'(1));
   endfunction

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/alu_adder.sv
// Plain ripple-style adder with carry in/out; shared with the single-cycle ALU.
module alu_adder
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            cin,
   output logic [XLEN-1:0] sum,
   output logic            cout
);

   logic [XLEN:0] w_full;

   assign w_full = (XLEN+1)'(a) + (XLEN+1)'(b) + (XLEN+1)'(cin);
   assign sum    = w_full[XLEN-1:0];
   assign cout   = w_full[XLEN];

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module alu_div_seq
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   div_state_e       r_state;
   div_state_e       w_state_nxt;
   div_op_e          r_op;
   logic [XLEN-1:0]  r_dvd;
   logic [XLEN-1:0]  r_dvs;
   logic [XLEN-1:0]  r_rem;
   logic [CNT_W-1:0] r_cnt;
   logic             r_prep;
   logic             r_neg_q;
   logic             r_neg_r;

   logic             r_busy;
   logic             r_done;
   logic [XLEN-1:0]  r_result;

   logic             w_busy_c;
   logic             w_done_c;
   logic [XLEN-1:0]  w_result_c;

   logic [XLEN-1:0]  w_rem_sh;
   logic [XLEN-1:0]  w_dvs_n;
   logic [XLEN-1:0]  w_diff;
   logic             w_cout;
   logic             w_qbit;
   logic             w_accept;
   logic             w_last;
   logic             w_in_signed;

   assign w_accept    = (r_state == IDLE) && start;
   assign w_last      = (r_state == CALC) && !r_prep && (r_cnt == CNT_W'(DIV_ITER - 1));
   assign w_in_signed = op_is_signed(div_op_e'(op));

   // Trial subtraction rem' - dvs as rem' + ~dvs + 1; cout=1 means no borrow.
   assign w_rem_sh = {r_rem[XLEN-2:0], r_dvd[XLEN-1]};
   assign w_dvs_n  = ~r_dvs;

   alu_adder u_trial_sub (
      .a    (w_rem_sh),
      .b    (w_dvs_n),
      .cin  (1'b1),
      .sum  (w_diff),
      .cout (w_cout)
   );

   // A set MSB shifted out of rem makes rem' exceed any 32-bit divisor.
   assign w_qbit = r_rem[XLEN-1] | w_cout;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_nxt = CALC;
         CALC:    if (w_last) w_state_nxt = FIX;
         FIX:                 w_state_nxt = IDLE;
         default:             w_state_nxt = IDLE;
      endcase
   end

   // Outputs lag the state by one register stage; result only changes in FIX.
   always_comb begin
      w_busy_c   = (r_state == CALC);
      w_done_c   = (r_state == FIX);
      w_result_c = r_result;
      if (r_state == FIX) begin
         case (r_op)
            DIV:     w_result_c = r_neg_q ? neg2c(r_dvd) : r_dvd;
            DIVU:    w_result_c = r_dvd;
            REM:     w_result_c = r_neg_r ? neg2c(r_rem) : r_rem;
            REMU:    w_result_c = r_rem;
            default: w_result_c = r_result;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_busy   <= w_busy_c;
         r_done   <= w_done_c;
         r_result <= w_result_c;
      end
   end

   // Operands are latched raw; magnitudes are taken in the first CALC cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op    <= DIV;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_prep  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_op    <= div_op_e'(op);
         r_dvd   <= a;
         r_dvs   <= b;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_prep  <= 1'b1;
         r_neg_q <= w_in_signed && (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
         r_neg_r <= w_in_signed && a[XLEN-1];
      end else if (r_state == CALC) begin
         if (r_prep) begin
            r_prep <= 1'b0;
            if (op_is_signed(r_op) && r_dvd[XLEN-1]) r_dvd <= neg2c(r_dvd);
            if (op_is_signed(r_op) && r_dvs[XLEN-1]) r_dvs <= neg2c(r_dvs);
         end else begin
            r_rem <= w_qbit ? w_diff : w_rem_sh;
            r_dvd <= {r_dvd[XLEN-2:0], w_qbit};
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed and randomized checks for the sequential divide unit.
module tb_alu_div_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   always #5 clk = ~clk;

   alu_div_seq dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called #1 after a rising edge; returns result and edge count to done (0 = none).
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      res = 32'hxxxx_xxxx;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            res = result;
            break;
         end
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      sx = x;
      sy = y;
      if (y == 32'd0)                                        return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         OP_DIV:  return sx / sy;
         OP_DIVU: return x / y;
         OP_REM:  return sx % sy;
         default: return x % y;
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      logic [31:0] r;
      int l;
      run_op(OP_DIVU, 32'd100, 32'd7, r, l);
      total++; if (l != 34)      begin bad++; $display("FAIL divu_latency: got %0d want 34", l); end
      total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7: got %h want 0000000e", r); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_in_done: got %b want 0", busy); end
      @(posedge clk); #1;
      run_op(OP_REMU, 32'd100, 32'd7, r, l);
      total++; if (r !== 32'd2)  begin bad++; $display("FAIL remu_100_7: got %h want 00000002", r); end
   endtask

   task automatic test_signed();
      logic [31:0] r;
      int l;
      run_op(OP_DIV, 32'hFFFF_FFEC, 32'd3, r, l);
      total++; if (r !== 32'hFFFF_FFFA) begin bad++; $display("FAIL div_m20_3: got %h want fffffffa", r); end
      run_op(OP_REM, 32'hFFFF_FFEC, 32'd3, r, l);
      total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rem_m20_3: got %h want fffffffe", r); end
      run_op(OP_DIV, 32'd20, 32'hFFFF_FFFD, r, l);
      total++; if (r !== 32'hFFFF_FFFA) begin bad++; $display("FAIL div_20_m3: got %h want fffffffa", r); end
      run_op(OP_REM, 32'd20, 32'hFFFF_FFFD, r, l);
      total++; if (r !== 32'd2)         begin bad++; $display("FAIL rem_20_m3: got %h want 00000002", r); end
   endtask

   task automatic test_div_zero();
      logic [31:0] r;
      int l;
      run_op(OP_DIVU, 32'h1234_5678, 32'd0, r, l);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by0: got %h want ffffffff", r); end
      run_op(OP_DIV, 32'h1234_5678, 32'd0, r, l);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_by0: got %h want ffffffff", r); end
      total++; if (l != 34)             begin bad++; $display("FAIL div_by0_latency: got %0d want 34", l); end
      run_op(OP_REMU, 32'h1234_5678, 32'd0, r, l);
      total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL remu_by0: got %h want 12345678", r); end
      run_op(OP_REM, 32'h1234_5678, 32'd0, r, l);
      total++; if (r !== 32'h1234_5678) begin bad++; $display("FAIL rem_by0: got %h want 12345678", r); end
      run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, r, l);
      total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_by0: got %h want ffffffff", r); end
   endtask

   task automatic test_overflow();
      logic [31:0] r;
      int l;
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
      total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf: got %h want 80000000", r); end
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
      total++; if (r !== 32'd0)         begin bad++; $display("FAIL rem_ovf: got %h want 00000000", r); end
      run_op(OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, r, l);
      total++; if (r !== 32'd0)         begin bad++; $display("FAIL divu_big: got %h want 00000000", r); end
      run_op(OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, r, l);
      total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL remu_big: got %h want fffffffe", r); end
   endtask

   task automatic test_handshake();
      int pulses;
      int done_at;
      logic [31:0] r;
      logic busy_first;
      logic busy_last;
      pulses = 0; done_at = 0; r = '0; busy_first = 1'b0; busy_last = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (k == 1)  busy_first = busy;
         if (k == 33) busy_last  = busy;
         if (done) begin pulses++; done_at = k; r = result; end
         if (k == 5 || k == 20) begin start = 1'b1; op = OP_REMU; a = 32'd7; b = 32'd3; end
         if (k == 10) begin a = 32'hDEAD_BEEF; b = 32'd1; op = OP_DIV; end
      end
      start = 1'b0;
      total++; if (pulses != 1)      begin bad++; $display("FAIL hs_pulses: got %0d want 1", pulses); end
      total++; if (done_at != 34)    begin bad++; $display("FAIL hs_latency: got %0d want 34", done_at); end
      total++; if (r !== 32'd100)    begin bad++; $display("FAIL hs_result: got %h want 00000064", r); end
      total++; if (busy_first !== 1'b1) begin bad++; $display("FAIL hs_busy_first: got %b want 1", busy_first); end
      total++; if (busy_last !== 1'b1)  begin bad++; $display("FAIL hs_busy_last: got %b want 1", busy_last); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      int l;
      @(posedge clk); #1;
      run_op(OP_DIVU, 32'd1000, 32'd10, r, l);
      total++; if (r !== 32'd100) begin bad++; $display("FAIL b2b_first: got %h want 00000064", r); end
      run_op(OP_REMU, 32'd1001, 32'd10, r, l);
      total++; if (l != 34)       begin bad++; $display("FAIL b2b_latency: got %0d want 34", l); end
      total++; if (r !== 32'd1)   begin bad++; $display("FAIL b2b_second: got %h want 00000001", r); end
   endtask

   task automatic test_reset_midop();
      int pulses;
      logic [31:0] r;
      int l;
      pulses = 0;
      @(posedge clk); #1;
      start = 1'b1; op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
      total++; if (result !== 32'd0) begin bad++; $display("FAIL midrst_result: got %h want 0", result); end
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      total++; if (pulses != 0)      begin bad++; $display("FAIL midrst_no_done: got %0d want 0", pulses); end
      run_op(OP_DIVU, 32'd9, 32'd3, r, l);
      total++; if (r !== 32'd3)      begin bad++; $display("FAIL midrst_recover: got %h want 00000003", r); end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp_r;
      logic [1:0]  o;
      int l;
      for (int i = 0; i < 1000; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2: y = 32'($urandom_range(1, 15));
            3: x = 32'h8000_0000;
            4: y = y >> $urandom_range(1, 31);
            default: ;
         endcase
         if ($urandom_range(0, 15) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
         exp_r = ref_model(o, x, y);
         run_op(o, x, y, r, l);
         total++;
         if (r !== exp_r) begin
            bad++;
            $display("FAIL rand_result op=%0d a=%h b=%h: got %h want %h", o, x, y, r, exp_r);
         end
         total++;
         if (l != 34) begin
            bad++;
            $display("FAIL rand_latency op=%0d a=%h b=%h: got %0d want 34", o, x, y, l);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_handshake();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
